fifo_rd_packer: RTL and testbench
=================================

// Module: fifo_rd_packer
// PURPOSE
//  Read-side consumer of the async FIFO, in the FIFO read-clock domain. Pops DW-bit entries through the
//  FIFO's REQ/EMPTY read port and packs RATIO of them into one wide word. The word goes out on a
//  valid/ready stream and sustains 1 pop/cycle while the sink accepts.
// PARAMETERS
//  DW     8   FIFO entry width (bits)
//  RATIO  4   entries per output word, >=2; output width ODW = DW*RATIO
//  CW     derived localparam = $clog2(RATIO+1), lane-count width
// PORTS
//  I_CLK         in   1         clock (FIFO read clock)
//  I_RST         in   1         synchronous reset, active-high
//  I_FIFO_EMPTY  in   1         FIFO empty flag
//  I_FIFO_DATA   in   DW        FIFO head entry, valid whenever !I_FIFO_EMPTY
//  O_FIFO_REQ    out  1         pop request; entry consumed on the same rising edge
//  O_DATA        out  DW*RATIO  packed word; first-popped entry in [DW-1:0]
//  O_KEEP        out  RATIO     lane-valid mask for O_DATA
//  O_VALID       out  1         output word valid
//  I_READY       in   1         sink accepts word when O_VALID && I_READY at the edge
//  I_FLUSH       in   1         emit partial word (present only with FIFO_RD_PACKER_FLUSH_EN)
// BEHAVIOUR
//  - Clock and reset: single clock I_CLK; reset is synchronous and active-high (I_RST).
//  - Reset values: O_VALID=0, O_DATA=0, O_KEEP=0, lane count cnt=0, flush_pend=0.
//  - O_FIFO_REQ is forced to 0 while I_RST=1. Reset mid-word discards the partial word and any held output word.
//  - Accumulator: lane regs plus cnt (0..RATIO). State FILL when cnt<RATIO, FULL when cnt==RATIO.
//  - xfer = (cnt==RATIO || flush_fire) && (!O_VALID || I_READY)
//    - Loads the output reg with O_DATA=lanes and O_KEEP=mask, then sets O_VALID=1.
//  - Output reg states: IDLE (O_VALID=0) and HOLD (O_VALID=1).
//    - HOLD -> IDLE on I_READY with no xfer.
//    - HOLD stays HOLD on I_READY when xfer is also true (back-to-back words).
//    - O_DATA and O_KEEP are stable while O_VALID && !I_READY.
//  - O_FIFO_REQ = !I_RST && !I_FIFO_EMPTY && !flush_pend && (cnt<RATIO || xfer).
//    - Combinational path from I_READY; intentional, gives zero-bubble throughput.
//  - Pop writes I_FIFO_DATA into lane[cnt], then cnt++.
//  - Pop in the same cycle as xfer: the new entry goes to lane 0 and cnt becomes 1.
//  - Pop latency: an entry popped at edge N that completes a word is visible on O_VALID at N+1
//    if the output reg is free, otherwise on the first cycle after I_READY.
//  - Lane registers not yet written in the current word read back as 0 in O_DATA.
//  - Empty FIFO: no pop; accumulator holds its state indefinitely (no timeout).
//  - Full word with busy sink: accumulator stays FULL and O_FIFO_REQ=0. Back-pressure reaches the FIFO only this way.
// CONFIGURATION
//  FIFO_RD_PACKER_FLUSH_EN
//   - Defined: I_FLUSH port exists.
//     - I_FLUSH=1 at an edge with 0<cnt<RATIO sets flush_pend=1. Pops stop while flush_pend=1.
//     - flush_fire = flush_pend. Partial word transfers with O_KEEP = (1<<cnt)-1, upper lanes zero.
//     - xfer clears flush_pend and resets cnt to 0.
//     - I_FLUSH with cnt==0 or cnt==RATIO is ignored. I_FLUSH while flush_pend=1 is ignored.
//   - Undefined: no I_FLUSH port, flush_fire=0, O_KEEP is always all-ones when O_VALID=1.
// TESTING
//  - Reset: I_RST=1 for 3 cycles with FIFO non-empty and I_READY=1
//    -> O_FIFO_REQ=0 throughout, O_VALID=0, O_DATA=0, O_KEEP=0.
//  - Streaming, DW=8, RATIO=4: FIFO holds 0x01..0x08, I_READY=1
//    -> 8 consecutive pops, O_DATA=0x04030201 then 0x08070605, O_KEEP=4'hF, no idle cycles.
//  - Back-pressure: 12 entries, I_READY=0 for 20 cycles, then I_READY=1
//    -> exactly 8 pops during the stall, first word held stable, then 3 words in order.
//  - Starved FIFO: entries 0xA1,0xA2,0xA3, then 30 empty cycles, then 0xA4
//    -> no O_VALID until 0xA4 is popped, then O_DATA=0xA4A3A2A1.
//  - Reset mid-word: pop 0x11,0x22, assert I_RST, then push 0x33..0x36
//    -> first word out is 0x36353433.
//  - Flush (macro on): pop 0x55,0x66, pulse I_FLUSH with 0x77 waiting in the FIFO
//    -> O_DATA=0x00006655, O_KEEP=4'b0011, 0x77 not popped until after the xfer.

Source files
------------

// File: rtl/fifo_rd_packer.sv
// -----------------------------------------------------------------------------
// fifo_rd_packer
//   Read-side consumer of an async FIFO. It runs in the FIFO read-clock domain.
//   It pops DW-bit entries through the FIFO REQ/EMPTY read port and packs RATIO
//   of them into one DW*RATIO-bit word, with the first-popped entry in the
//   low lane. Words leave on a valid/ready stream. While the sink accepts, the
//   block sustains one pop per cycle.
//
//   Optional feature macro: FIFO_RD_PACKER_FLUSH_EN
//     When defined, the I_FLUSH port exists. A pulse with a partially filled
//     accumulator (0 < cnt < RATIO) emits the partial word. O_KEEP then marks
//     only the filled lanes, and pops are paused until that word is transferred.
//     When undefined, every emitted word is full and O_KEEP is all-ones.
//
// Ports
//   I_CLK         FIFO read clock
//   I_RST         synchronous reset, active-high
//   I_FIFO_EMPTY  FIFO empty flag
//   I_FIFO_DATA   FIFO head entry, valid whenever !I_FIFO_EMPTY
//   O_FIFO_REQ    pop request; the head entry is consumed at the same rising edge
//   O_DATA        packed output word
//   O_KEEP        lane-valid mask for O_DATA
//   O_VALID       output word valid
//   I_READY       sink ready
//   I_FLUSH       emit a partial word (FIFO_RD_PACKER_FLUSH_EN only)
//   O_DBG_STATE   {accumulator state (1 = FULL), output state (1 = HOLD)}
//
// Handshake: a word transfers at a rising edge where O_VALID && I_READY.
//   O_VALID never drops, and O_DATA/O_KEEP never change, while the word waits
//   for I_READY. O_FIFO_REQ depends combinationally on I_READY, so a completed
//   word can leave and the next pop can happen in the same cycle.
// -----------------------------------------------------------------------------
module fifo_rd_packer #(
    parameter int DW    = 8,
    parameter int RATIO = 4
) (
    input  logic                I_CLK,
    input  logic                I_RST,
    input  logic                I_FIFO_EMPTY,
    input  logic [DW-1:0]       I_FIFO_DATA,
    output logic                O_FIFO_REQ,
    output logic [DW*RATIO-1:0] O_DATA,
    output logic [RATIO-1:0]    O_KEEP,
    output logic                O_VALID,
    input  logic                I_READY,
`ifdef FIFO_RD_PACKER_FLUSH_EN
    input  logic                I_FLUSH,
`endif
    output logic [1:0]          O_DBG_STATE
);

    localparam int             CW       = $clog2(RATIO + 1);
    localparam int             ODW      = DW * RATIO;
    localparam logic [CW-1:0]  CNT_FULL = CW'(RATIO);

    typedef enum logic { ACC_FILL = 1'b0, ACC_FULL = 1'b1 } acc_state_t;
    typedef enum logic { OUT_IDLE = 1'b0, OUT_HOLD = 1'b1 } out_state_t;

    logic [CW-1:0]  r_cnt;
    logic [DW-1:0]  r_lane [RATIO];
    logic [ODW-1:0] r_data;
    logic [RATIO-1:0] r_keep;
    out_state_t     r_out_state;
    out_state_t     w_out_next;
    acc_state_t     w_acc_state;

    logic           w_flush_pend;
    logic           w_xfer;
    logic           w_pop;
    logic [ODW-1:0] w_packed;
    logic [RATIO-1:0] w_mask;

    assign w_acc_state = (r_cnt == CNT_FULL) ? ACC_FULL : ACC_FILL;

`ifdef FIFO_RD_PACKER_FLUSH_EN
    logic r_flush_pend;
    logic w_flush_start;

    // A flush is only meaningful for a partial word. It is ignored when the
    // accumulator is empty, when it is already full, and while a flush is
    // already pending. It can never coincide with a transfer, because a
    // transfer needs a full accumulator or a pending flush.
    assign w_flush_start = I_FLUSH && !r_flush_pend
                           && (r_cnt != '0) && (r_cnt < CNT_FULL);

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            r_flush_pend <= 1'b0;
        end else if (w_xfer) begin
            r_flush_pend <= 1'b0;
        end else if (w_flush_start) begin
            r_flush_pend <= 1'b1;
        end
    end

    assign w_flush_pend = r_flush_pend;
`else
    assign w_flush_pend = 1'b0;
`endif

    // Move the accumulator into the output register. This happens when a
    // word is ready and the output register is empty or being drained.
    assign w_xfer = ((w_acc_state == ACC_FULL) || w_flush_pend)
                    && (!O_VALID || I_READY);

    // Pop while there is room. A full accumulator makes room only when its
    // word transfers in this same cycle; this is the sole back-pressure path
    // to the FIFO.
    assign w_pop = !I_RST && !I_FIFO_EMPTY && !w_flush_pend
                   && ((w_acc_state == ACC_FILL) || w_xfer);

    always_comb begin
        w_packed = '0;
        w_mask   = '0;
        for (int i = 0; i < RATIO; i++) begin
            w_packed[i*DW +: DW] = r_lane[i];
            w_mask[i]            = (CW'(i) < r_cnt);
        end
    end

    // Accumulator. On a transfer the lanes are cleared, so that unwritten
    // lanes of the next word read back as zero. A pop in the same cycle
    // restarts the next word at lane 0.
    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            r_cnt <= '0;
            for (int i = 0; i < RATIO; i++) begin
                r_lane[i] <= '0;
            end
        end else if (w_xfer) begin
            r_cnt <= w_pop ? CW'(1) : '0;
            for (int i = 0; i < RATIO; i++) begin
                r_lane[i] <= (i == 0 && w_pop) ? I_FIFO_DATA : '0;
            end
        end else if (w_pop) begin
            r_cnt <= r_cnt + CW'(1);
            for (int i = 0; i < RATIO; i++) begin
                if (r_cnt == CW'(i)) begin
                    r_lane[i] <= I_FIFO_DATA;
                end
            end
        end
    end

    // Output register. It is loaded only on a transfer, so it stays stable
    // while a word waits for the sink.
    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            r_data <= '0;
            r_keep <= '0;
        end else if (w_xfer) begin
            r_data <= w_packed;
            r_keep <= w_mask;
        end
    end

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            r_out_state <= OUT_IDLE;
        end else begin
            r_out_state <= w_out_next;
        end
    end

    always_comb begin
        w_out_next = r_out_state;
        case (r_out_state)
            OUT_IDLE: begin
                if (w_xfer) w_out_next = OUT_HOLD;
            end
            OUT_HOLD: begin
                if (w_xfer)       w_out_next = OUT_HOLD;
                else if (I_READY) w_out_next = OUT_IDLE;
            end
            default: w_out_next = OUT_IDLE;
        endcase
    end

    assign O_VALID     = (r_out_state == OUT_HOLD);
    assign O_DATA      = r_data;
    assign O_KEEP      = r_keep;
    assign O_FIFO_REQ  = w_pop;
    assign O_DBG_STATE = {w_acc_state == ACC_FULL, r_out_state == OUT_HOLD};

endmodule

// File: tb/tb_fifo_rd_packer.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_packer
//   Self-checking bench for fifo_rd_packer (DW=8, RATIO=4). The bench models
//   the FIFO as a queue. Each entry pushed into that queue also feeds a small
//   packing model, and every completed (or flushed) word goes onto the
//   expected queue. Words accepted by the sink are popped from the expected
//   queue and compared against it.
// -----------------------------------------------------------------------------
module tb_fifo_rd_packer;

    localparam int DW    = 8;
    localparam int RATIO = 4;
    localparam int ODW   = DW * RATIO;

    logic             I_CLK;
    logic             I_RST;
    logic             I_FIFO_EMPTY;
    logic [DW-1:0]    I_FIFO_DATA;
    logic             O_FIFO_REQ;
    logic [ODW-1:0]   O_DATA;
    logic [RATIO-1:0] O_KEEP;
    logic             O_VALID;
    logic             I_READY;
    logic [1:0]       O_DBG_STATE;
`ifdef FIFO_RD_PACKER_FLUSH_EN
    logic             I_FLUSH;
`endif

    fifo_rd_packer #(.DW(DW), .RATIO(RATIO)) dut (
        .I_CLK        (I_CLK),
        .I_RST        (I_RST),
        .I_FIFO_EMPTY (I_FIFO_EMPTY),
        .I_FIFO_DATA  (I_FIFO_DATA),
        .O_FIFO_REQ   (O_FIFO_REQ),
        .O_DATA       (O_DATA),
        .O_KEEP       (O_KEEP),
        .O_VALID      (O_VALID),
        .I_READY      (I_READY),
`ifdef FIFO_RD_PACKER_FLUSH_EN
        .I_FLUSH      (I_FLUSH),
`endif
        .O_DBG_STATE  (O_DBG_STATE)
    );

    // ---------------- clock / reset ----------------
    initial I_CLK = 1'b0;
    always #5 I_CLK = ~I_CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [DW-1:0]        fifo_q [$];
    logic [ODW+RATIO-1:0] exp_q  [$];
    logic [DW-1:0]        m_lane [RATIO];
    int                   m_cnt;
    int                   n_checks;
    int                   n_pass;
    int                   pop_count;
    int                   valid_seen;
    int                   words_seen;
    logic                 hold_prev;
    logic [ODW+RATIO-1:0] held;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [ODW+RATIO-1:0] model_word(input int n);
        logic [ODW-1:0]   w;
        logic [RATIO-1:0] k;
        w = '0;
        k = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (i < n) begin
                w[i*DW +: DW] = m_lane[i];
                k[i]          = 1'b1;
            end
        end
        return {k, w};
    endfunction

    task automatic push_entry(input logic [DW-1:0] d);
        fifo_q.push_back(d);
        m_lane[m_cnt] = d;
        m_cnt++;
        if (m_cnt == RATIO) begin
            exp_q.push_back(model_word(RATIO));
            m_cnt = 0;
        end
    endtask

    task automatic model_flush();
        exp_q.push_back(model_word(m_cnt));
        m_cnt = 0;
    endtask

    // ---------------- driver ----------------
    task automatic drive_fifo();
        I_FIFO_EMPTY = (fifo_q.size() == 0);
        I_FIFO_DATA  = (fifo_q.size() == 0) ? '0 : fifo_q[0];
    endtask

    // One clock cycle: the DUT is sampled mid-cycle (after the falling edge),
    // then the model FIFO is updated just after the rising edge.
    task automatic cycle();
        logic pop;
        @(negedge I_CLK);
        drive_fifo();
        #1;
        pop = O_FIFO_REQ;
        if (I_RST) begin
            check("req_in_reset", {63'b0, O_FIFO_REQ}, 64'd0);
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_valid", {63'b0, O_VALID}, 64'd1);
                check("hold_stable", {28'b0, O_KEEP, O_DATA}, {28'b0, held});
            end
            if (O_VALID && I_READY) begin
                check("word_expected", {63'b0, exp_q.size() != 0}, 64'd1);
                if (exp_q.size() != 0) check("word", {28'b0, O_KEEP, O_DATA}, {28'b0, exp_q.pop_front()});
                words_seen++;
            end
            if (O_VALID) valid_seen++;
            hold_prev = O_VALID && !I_READY;
            held      = {O_KEEP, O_DATA};
        end
        @(posedge I_CLK);
        #1;
        if (pop) begin
            check("pop_nonempty", {63'b0, fifo_q.size() != 0}, 64'd1);
            if (fifo_q.size() != 0) fifo_q.delete(0);
            pop_count++;
        end
        drive_fifo();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        I_READY = 1'b1;
        while ((exp_q.size() != 0 || fifo_q.size() != 0) && n < budget) begin
            cycle();
            n++;
        end
        repeat (2) cycle();
        check("drain_done", 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int w0;
        int pushed;
        n_checks   = 0;
        n_pass     = 0;
        pop_count  = 0;
        valid_seen = 0;
        words_seen = 0;
        hold_prev  = 1'b0;
        held       = '0;
        m_cnt      = 0;
        for (int i = 0; i < RATIO; i++) m_lane[i] = '0;
        I_RST   = 1'b1;
        I_READY = 1'b1;
`ifdef FIFO_RD_PACKER_FLUSH_EN
        I_FLUSH = 1'b0;
`endif

        // Reset with a non-empty FIFO and a ready sink.
        for (int d = 1; d <= 8; d++) push_entry(DW'(d));
        drive_fifo();
        repeat (3) cycle();
        check("rst_valid", {63'b0, O_VALID}, 64'd0);
        check("rst_data", {32'b0, O_DATA}, 64'd0);
        check("rst_keep", {60'b0, O_KEEP}, 64'd0);
        check("rst_no_pop", 64'(pop_count), 64'd0);

        // Streaming: eight back-to-back pops, two full words.
        I_RST     = 1'b0;
        pop_count = 0;
        repeat (8) cycle();
        check("stream_pops", 64'(pop_count), 64'd8);
        drain(50);

        // Back-pressure: 12 entries, sink stalled for 20 cycles.
        I_READY   = 1'b0;
        for (int d = 0; d < 12; d++) push_entry(8'h20 + DW'(d));
        pop_count = 0;
        repeat (20) cycle();
        check("stall_pops", 64'(pop_count), 64'd8);
        check("stall_valid", {63'b0, O_VALID}, 64'd1);
        check("stall_req", {63'b0, O_FIFO_REQ}, 64'd0);
        w0 = words_seen;
        drain(100);
        check("stall_words", 64'(words_seen - w0), 64'd3);

        // Starved FIFO: three entries, a long gap, then the fourth.
        I_READY = 1'b1;
        push_entry(8'hA1);
        push_entry(8'hA2);
        push_entry(8'hA3);
        valid_seen = 0;
        repeat (30) cycle();
        check("starve_no_valid", 64'(valid_seen), 64'd0);
        check("starve_fifo_empty", 64'(fifo_q.size()), 64'd0);
        push_entry(8'hA4);
        drain(50);

        // Reset mid-word discards the partial word.
        push_entry(8'h11);
        push_entry(8'h22);
        repeat (4) cycle();
        check("midrst_popped", 64'(fifo_q.size()), 64'd0);
        I_RST = 1'b1;
        cycle();
        I_RST = 1'b0;
        m_cnt = 0;
        check("midrst_valid", {63'b0, O_VALID}, 64'd0);
        for (int d = 0; d < 4; d++) push_entry(8'h33 + DW'(d));
        drain(50);

`ifdef FIFO_RD_PACKER_FLUSH_EN
        // A flush with an empty accumulator is ignored.
        valid_seen = 0;
        I_FLUSH    = 1'b1;
        cycle();
        I_FLUSH    = 1'b0;
        repeat (3) cycle();
        check("flush_empty_ignored", 64'(valid_seen), 64'd0);

        // A partial word flush; 0x77 must wait until the flushed word has moved.
        push_entry(8'h55);
        push_entry(8'h66);
        repeat (3) cycle();
        I_FLUSH = 1'b1;
        cycle();
        I_FLUSH = 1'b0;
        model_flush();
        push_entry(8'h77);
        pop_count = 0;
        cycle();
        check("flush_no_pop", 64'(pop_count), 64'd0);
        check("flush_valid", {63'b0, O_VALID}, 64'd1);
        check("flush_keep", {60'b0, O_KEEP}, 64'h3);
        push_entry(8'h78);
        push_entry(8'h79);
        push_entry(8'h7A);
        drain(50);
`endif

        // Random pushes and a random sink-ready pattern.
        pushed = 0;
        for (int c = 0; c < 300; c++) begin
            if (pushed < 48 && $urandom_range(0, 1) == 1) begin
                push_entry(DW'($urandom_range(0, 255)));
                pushed++;
            end
            I_READY = ($urandom_range(0, 3) != 0);
            cycle();
        end
        while (pushed < 48) begin
            push_entry(DW'($urandom_range(0, 255)));
            pushed++;
        end
        drain(400);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
